// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register-read stage feeding the alu; define FORWARD_EN for same-cycle write-back bypass
module operand_fetch #(
  parameter int WORD_SIZE = 16,
  parameter int REG_COUNT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [2:0]           in_rs,
  input  logic [2:0]           in_rt,
  input  logic [2:0]           in_rd,
  input  logic                 in_imm_sel,
  input  logic [WORD_SIZE-1:0] in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_op,
  output logic [WORD_SIZE-1:0] out_in1,
  output logic [WORD_SIZE-1:0] out_in2,
  output logic [2:0]           out_rd,
  input  logic                 wb_en,
  input  logic [2:0]           wb_rd,
  input  logic [WORD_SIZE-1:0] wb_data
);

  // out_valid is the whole state: EMPTY when 0, FULL when 1
  localparam logic STATE_EMPTY = 1'b0;
  localparam logic STATE_FULL  = 1'b1;

  logic [WORD_SIZE-1:0] regs [REG_COUNT];
  logic [REG_COUNT-1:0] pending;
  logic [REG_COUNT-1:0] pending_next;

  logic                 wb_live;
  logic                 wb_hit_rs;
  logic                 wb_hit_rt;
  logic                 rs_block;
  logic                 rt_block;
  logic                 rd_block;
  logic                 slot_free;
  logic                 accept;
  logic [WORD_SIZE-1:0] rs_val;
  logic [WORD_SIZE-1:0] rt_val;

  // hazard detection and operand selection for the instruction on the input
  always_comb begin
    wb_live   = wb_en && (wb_rd != 3'd0);
    wb_hit_rs = wb_live && (wb_rd == in_rs);
    wb_hit_rt = wb_live && (wb_rd == in_rt);
`ifdef FORWARD_EN
    // a write-back landing this cycle resolves the hazard and supplies the value
    rs_block = (in_rs != 3'd0) && pending[in_rs] && !wb_hit_rs;
    rt_block = !in_imm_sel && (in_rt != 3'd0) && pending[in_rt] && !wb_hit_rt;
    rs_val   = (in_rs == 3'd0) ? '0 : (wb_hit_rs ? wb_data : regs[in_rs]);
    rt_val   = (in_rt == 3'd0) ? '0 : (wb_hit_rt ? wb_data : regs[in_rt]);
`else
    // without bypass, a source being written this cycle must wait one more cycle
    rs_block = (in_rs != 3'd0) && (pending[in_rs] || wb_hit_rs);
    rt_block = !in_imm_sel && (in_rt != 3'd0) && (pending[in_rt] || wb_hit_rt);
    rs_val   = (in_rs == 3'd0) ? '0 : regs[in_rs];
    rt_val   = (in_rt == 3'd0) ? '0 : regs[in_rt];
`endif
    rd_block  = (in_rd != 3'd0) && pending[in_rd];
    slot_free = (out_valid == STATE_EMPTY) || out_ready;
    in_ready  = slot_free && !rs_block && !rt_block && !rd_block;
    accept    = in_valid && in_ready;
  end

  // pending scoreboard: write-back clears, accept sets; set wins on the same index
  always_comb begin
    pending_next = pending;
    if (wb_live) begin
      pending_next[wb_rd] = 1'b0;
    end
    if (accept && (in_rd != 3'd0)) begin
      pending_next[in_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // register file write-back; register 0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_live) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // pending bits register
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // output slot: load on accept, empty on drain, hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= STATE_EMPTY;
      out_op    <= '0;
      out_in1   <= '0;
      out_in2   <= '0;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= STATE_FULL;
      out_op    <= in_op;
      out_in1   <= rs_val;
      out_in2   <= in_imm_sel ? in_imm : rt_val;
      out_rd    <= in_rd;
    end else if (out_valid && out_ready) begin
      out_valid <= STATE_EMPTY;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch (FORWARD_EN aware)
module tb_operand_fetch;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_MUL   = 3'd2;
  localparam logic [2:0] ALU_SHIFT = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_rs;
  logic [2:0]  in_rt;
  logic [2:0]  in_rd;
  logic        in_imm_sel;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_op;
  logic [15:0] out_in1;
  logic [15:0] out_in2;
  logic [2:0]  out_rd;
  logic        wb_en;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_in1(out_in1), .out_in2(out_in2), .out_rd(out_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [2:0]  rd;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_regs [8];
  logic [7:0]  m_pend;
  logic        m_full;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] idx);
    if (idx == 3'd0) return 16'd0;
`ifdef FORWARD_EN
    if (wb_en && wb_rd == idx) return wb_data;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic m_src_blocks(input logic [2:0] idx);
    logic hit;
    hit = wb_en && (wb_rd == idx);
    if (idx == 3'd0) return 1'b0;
`ifdef FORWARD_EN
    return m_pend[idx] && !hit;
`else
    return m_pend[idx] || hit;
`endif
  endfunction

  function automatic logic m_ready();
    logic blk;
    blk = m_src_blocks(in_rs) || (!in_imm_sel && m_src_blocks(in_rt)) ||
          ((in_rd != 3'd0) && m_pend[in_rd]);
    return (!m_full || out_ready) && !blk;
  endfunction

  // one clock: check outputs against the model, advance the model, cross the edge
  task automatic step();
    logic  exp_ready;
    logic  acc;
    exp_t  e;
    #1;
    exp_ready = m_ready();
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, m_full);
    if (m_full) begin
      if (sb.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        check("out_op", out_op, sb[0].op);
        check("out_in1", out_in1, sb[0].in1);
        check("out_in2", out_in2, sb[0].in2);
        check("out_rd", out_rd, sb[0].rd);
      end
    end
    if (rst) begin
      sb.delete();
      m_full = 1'b0;
      m_pend = '0;
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
    end else begin
      acc = in_valid && exp_ready;
      if (m_full && out_ready && sb.size() != 0) void'(sb.pop_front());
      if (acc) begin
        e.op  = in_op;
        e.in1 = m_read(in_rs);
        e.in2 = in_imm_sel ? in_imm : m_read(in_rt);
        e.rd  = in_rd;
        sb.push_back(e);
      end
      if (wb_en && wb_rd != 3'd0) begin
        m_regs[wb_rd] = wb_data;
        m_pend[wb_rd] = 1'b0;
      end
      if (acc && in_rd != 3'd0) m_pend[in_rd] = 1'b1;
      m_full = acc ? 1'b1 : ((m_full && out_ready) ? 1'b0 : m_full);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd, input logic sel, input logic [15:0] imm);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm_sel = sel; in_imm = imm;
  endtask

  task automatic wb(input logic [2:0] rd, input logic [15:0] data);
    wb_en = 1'b1; wb_rd = rd; wb_data = data;
  endtask

  task automatic idle();
    in_valid = 1'b0; wb_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    in_valid = 0; in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm_sel = 0; in_imm = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0;
    m_full = 1'b0; m_pend = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_op", out_op, 0);
    check("rst_out_in1", out_in1, 0);
    check("rst_out_in2", out_in2, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_in_ready", in_ready, 1);

    // 1: first instruction after reset
    issue(ALU_ADD, 3'd1, 3'd2, 3'd3, 1'b0, 16'd0);
    step();
    idle();
    check("t1_valid", out_valid, 1);
    check("t1_in1", out_in1, 0);
    check("t1_in2", out_in2, 0);
    check("t1_rd", out_rd, 3);
    in_rs = 3'd3; in_rt = 3'd0; in_rd = 3'd0;
    #1;
    check("t1_pend3", in_ready, 0);
    step();
    wb(3'd3, 16'd1);
    step();

    // 2: register reads and immediate select
    wb(3'd1, 16'd5);
    step();
    wb(3'd2, 16'd7);
    step();
    idle();
    issue(ALU_MUL, 3'd1, 3'd2, 3'd6, 1'b0, 16'd0);
    step();
    check("t2_mul_in1", out_in1, 5);
    check("t2_mul_in2", out_in2, 7);
    check("t2_mul_op", out_op, ALU_MUL);
    issue(ALU_SHIFT, 3'd1, 3'd7, 3'd0, 1'b1, 16'd3);
    step();
    check("t2_shift_in1", out_in1, 5);
    check("t2_shift_in2", out_in2, 3);

    // 3: downstream stall holds the slot
    out_ready = 1'b0;
    issue(ALU_ADD, 3'd1, 3'd2, 3'd0, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_stall_ready", in_ready, 0);
      step();
      check("t3_hold_in2", out_in2, 3);
    end
    out_ready = 1'b1;
    #1;
    check("t3_release_ready", in_ready, 1);
    step();
    check("t3_new_in2", out_in2, 7);
    wb(3'd6, 16'd9);
    idle();
    wb(3'd6, 16'd9);
    step();
    idle();

    // 4: read-after-write hazard on r4
    issue(ALU_ADD, 3'd1, 3'd2, 3'd4, 1'b0, 16'd0);
    step();
    issue(ALU_SUB, 3'd4, 3'd0, 3'd0, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_raw_stall", in_ready, 0);
      step();
    end
    wb(3'd4, 16'd12);
`ifdef FORWARD_EN
    #1;
    check("t4_fwd_ready", in_ready, 1);
    step();
    wb_en = 1'b0;
    in_valid = 1'b0;
    check("t4_fwd_in1", out_in1, 12);
`else
    #1;
    check("t4_nofwd_wbcycle", in_ready, 0);
    step();
    wb_en = 1'b0;
    #1;
    check("t4_nofwd_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t4_nofwd_in1", out_in1, 12);
`endif
    check("t4_op", out_op, ALU_SUB);
    step();

    // 5: register 0 rules and set-beats-clear
    wb(3'd0, 16'd99);
    step();
    idle();
    issue(ALU_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 16'd0);
    step();
    check("t5_r0_in1", out_in1, 0);
    check("t5_r0_in2", out_in2, 0);
    issue(ALU_ADD, 3'd0, 3'd0, 3'd1, 1'b0, 16'd0);
    #1;
    check("t5_r0_nostall", in_ready, 1);
    step();
    idle();
    wb(3'd1, 16'd5);
    step();
    idle();
    issue(ALU_ADD, 3'd1, 3'd2, 3'd5, 1'b0, 16'd0);
    wb(3'd5, 16'd55);
    step();
    idle();
    in_rs = 3'd5; in_rt = 3'd0; in_rd = 3'd0; in_imm_sel = 1'b0;
    #1;
    check("t5_pend5_kept", in_ready, 0);

    // 6: reset while stalled on a hazard with the slot full
    out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    check("t6_pre_valid", out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_op", out_op, 0);
    check("t6_in1", out_in1, 0);
    check("t6_in2", out_in2, 0);
    check("t6_rd", out_rd, 0);
    check("t6_ready_r5", in_ready, 1);
    issue(ALU_ADD, 3'd1, 3'd2, 3'd6, 1'b0, 16'd0);
    step();
    idle();
    check("t6_regs_cleared", out_in1, 0);
    step();
    step();
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read stage directly upstream of the `alu`. It holds the 8 × WORD_SIZE register file, accepts decoded instructions, and presents `op`, `in1` and `in2` to the ALU through a single registered output slot with a valid/ready handshake. A per-register pending scoreboard stalls read-after-write and write-after-write hazards. ALU results return through the write-back port.

## Interface
- WORD_SIZE, 16, datapath width; matches the ALU operand width.
- REG_COUNT, 8, number of architectural registers; register indices are 3 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  3  ALU opcode (ALU_ADD … ALU_SHIFT); passed through unchanged.
- in_rs, in_rt, in_rd  in  3 each  source A, source B and destination indices.
- in_imm_sel  in  1  1 = in2 comes from in_imm; rt is not read and not hazard-checked.
- in_imm  in  WORD_SIZE  immediate operand.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  downstream accepts.
- out_op  out  3; out_in1, out_in2  out  WORD_SIZE; out_rd  out  3  registered ALU inputs and destination tag.
- wb_en  in  1; wb_rd  in  3; wb_data  in  WORD_SIZE  result write-back.

## Operation
- Register 0 reads as 0. Writes to register 0 are ignored, and register 0 is never marked pending.
- **Write-back.** When wb_en=1 and wb_rd≠0:
  - reg[wb_rd] ← wb_data at the clock edge.
  - pending[wb_rd] is cleared.
- **Hazard.** An index "blocks" when it is nonzero and its pending bit is set. The blocking checks are:
  - rs always;
  - rt only when in_imm_sel=0;
  - rd when rd≠0 (write-after-write).
- **Slot free** = !out_valid || out_ready.
- **in_ready** = slot free && no blocking index. It is combinational from the current state and inputs.
- **Accept** (in_valid && in_ready):
  - Load the output slot: out_op=in_op, out_in1=read(rs), out_in2 = in_imm_sel ? in_imm : read(rt), out_rd=in_rd.
  - Set out_valid=1.
  - Set pending[in_rd] when in_rd≠0.
- **Drain.** If out_valid && out_ready and no new accept, out_valid ← 0. Output data is held; its value is don't-care.
- **Simultaneous set and clear** on the same index (accept with rd=X while wb_rd=X): set wins, because the new producer owns X.
- The state machine is implicit: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→FULL on accept+drain, or on stall.
  - FULL→EMPTY on drain without accept.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N has out_valid=1 after edge N.
- Throughput is 1 per cycle with no hazards and out_ready held at 1.
- While out_valid=1 and out_ready=0, every out_* signal is held stable and in_ready=0.
- A write-back at edge N is visible to register reads for instructions accepted at edge N+1 or later. Same-cycle behaviour is set by the configuration below.
- **Reset** (rst=1 at an edge) overrides every other event in that cycle, including mid-stall or with out_valid=1:
  - all registers = 0, pending = 0;
  - out_valid=0, out_op=0, out_in1=0, out_in2=0, out_rd=0.
- in_ready is 1 the cycle after reset is released.

## Configuration
- FORWARD_EN defined:
  - A write-back in the same cycle as an accept is bypassed. If wb_en && wb_rd==rs (or rt), wb_data is used as the operand.
  - A pending source cleared by that same-cycle write-back does not block.
  - A RAW hazard therefore costs 0 extra cycles after the write-back arrives.
- FORWARD_EN undefined:
  - No bypass.
  - Any source matching the same-cycle wb_rd blocks, in addition to the pending check.
  - Accept happens at the earliest one cycle after the write-back, and the read returns the newly written value.

## Test plan
1. Reset, then issue ALU_ADD with rs=1, rt=2, rd=3 → next cycle out_valid=1, in1=0, in2=0, out_rd=3, and pending[3] is set.
2. Write back r1=5 and r2=7, then issue ALU_MUL with rs=1, rt=2 → out_in1=5, out_in2=7. Issue ALU_SHIFT with rs=1 and imm 3 (in_imm_sel=1) → out_in2=3.
3. Hold out_ready=0 for 3 cycles while out_valid=1 → out_* stable and in_ready=0 throughout. Raise out_ready → the next instruction is accepted that same cycle.
4. RAW hazard: issue rd=4, then issue an instruction reading r4 → in_ready=0 until wb r4=12.
   - FORWARD_EN defined: accepted in the write-back cycle with in1=12.
   - FORWARD_EN undefined: accepted one cycle later with in1=12.
5. Write back r0=99 → a read of r0 returns 0. Issue with rd=0 → no stall on a later reader of r0. Issue rd=5 and write back r5 in the same cycle → pending[5] remains set.
6. Assert rst while stalled on a hazard with out_valid=1 → next cycle out_valid=0, all out_* = 0, pending cleared, in_ready=1.
